// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS decode definitions: opcodes, funct codes, control-signal bit
// positions, ALU codes and the decoded-entry record passed to execute.
package mips_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes accepted by execute
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Bit positions inside the 8-bit signals vector
    localparam int SIG_ALUSRC   = 7;
    localparam int SIG_MEMTOREG = 6;
    localparam int SIG_REGWRITE = 5;
    localparam int SIG_MEMREAD  = 4;
    localparam int SIG_MEMWRITE = 3;
    localparam int SIG_BRANCH   = 2;
    localparam int SIG_EQ       = 1;
    localparam int SIG_GOTO     = 0;

    // ALU function codes (share encoding with R-type funct)
    localparam logic [5:0] ALU_NONE = 6'h00;
    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_ADDU = 6'h21;
    localparam logic [5:0] ALU_SUB  = 6'h22;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_SLT  = 6'h2A;
    localparam logic [5:0] ALU_SLTU = 6'h2B;

    // One decoded instruction as held in the output buffer; the immediate
    // stays 16 bits plus an extension-kind flag and is widened at the output.
    typedef struct packed {
        logic        illegal;
        logic [7:0]  signals;
        logic [5:0]  aluctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic        imm_sext;
        logic [25:0] target;
    } dec_entry_t;

    localparam int DEC_W = $bits(dec_entry_t);

    // Occupancy of the output buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // True for R-type funct codes that execute implements
    function automatic logic funct_legal(input logic [5:0] funct);
        logic ok;
        case (funct)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_SLT, FN_SLTU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch->execute handshake bundle for the decode stage.
// ILLEGAL_TRAP_EN adds out_illegal to the bundle.
interface decode_stage_pipe_if #(parameter int XLEN = 32);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_signals;
    logic [5:0]        out_aluctrl;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_dest;
    logic [XLEN-1:0]   out_imm;
    logic [25:0]       out_target;
`ifdef ILLEGAL_TRAP_EN
    logic              out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_signals, out_aluctrl, out_rs, out_rt,
               out_dest, out_imm, out_target, out_illegal
    );
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_signals, out_aluctrl, out_rs, out_rt,
               out_dest, out_imm, out_target, out_illegal
    );
`else
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_signals, out_aluctrl, out_rs, out_rt,
               out_dest, out_imm, out_target
    );
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_signals, out_aluctrl, out_rs, out_rt,
               out_dest, out_imm, out_target
    );
`endif
endinterface

// File: rtl/decode_comb.sv
// Pure combinational MIPS instruction decoder: instruction word -> decoded entry.
// ILLEGAL_TRAP_EN flags unknown opcodes / unsupported R-type functs.
module decode_comb
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_entry_t  entry
);

    // Field extraction plus opcode table lookup
    always_comb begin
        entry          = '0;
        entry.rs       = instr[25:21];
        entry.rt       = instr[20:16];
        entry.dest     = instr[20:16];
        entry.imm      = instr[15:0];
        entry.target   = instr[25:0];
        entry.imm_sext = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                entry.dest    = instr[15:11];
                entry.aluctrl = instr[5:0];
`ifdef ILLEGAL_TRAP_EN
                entry.illegal = ~funct_legal(instr[5:0]);
`endif
                if (entry.illegal) begin
                    entry.signals = 8'h00;
                end else if (instr[5]) begin
                    entry.signals = 8'h20;
                end else begin
                    entry.signals = 8'h00;
                end
            end
            OP_LW:    begin entry.signals = 8'hF0; entry.aluctrl = ALU_ADD;  entry.imm_sext = 1'b1; end
            OP_SW:    begin entry.signals = 8'h88; entry.aluctrl = ALU_ADD;  entry.imm_sext = 1'b1; end
            OP_BEQ:   begin entry.signals = 8'h06; entry.aluctrl = ALU_SUB;  entry.imm_sext = 1'b1; end
            OP_BNE:   begin entry.signals = 8'h04; entry.aluctrl = ALU_SUB;  entry.imm_sext = 1'b1; end
            OP_ADDI:  begin entry.signals = 8'hA0; entry.aluctrl = ALU_ADD;  entry.imm_sext = 1'b1; end
            OP_ADDIU: begin entry.signals = 8'hA0; entry.aluctrl = ALU_ADDU; entry.imm_sext = 1'b1; end
            OP_ANDI:  begin entry.signals = 8'hA0; entry.aluctrl = ALU_AND;  entry.imm_sext = 1'b0; end
            OP_ORI:   begin entry.signals = 8'hA0; entry.aluctrl = ALU_OR;   entry.imm_sext = 1'b0; end
            OP_SLTI:  begin entry.signals = 8'hA0; entry.aluctrl = ALU_SLT;  entry.imm_sext = 1'b1; end
            OP_SLTIU: begin entry.signals = 8'hA0; entry.aluctrl = ALU_SLTU; entry.imm_sext = 1'b1; end
            OP_J:     begin entry.signals = 8'h01; entry.aluctrl = ALU_NONE; entry.imm_sext = 1'b0; end
            default: begin
                entry.signals = 8'h00;
                entry.aluctrl = ALU_NONE;
`ifdef ILLEGAL_TRAP_EN
                entry.illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered, flow-controlled MIPS decode stage with a 1- or 2-entry output
// buffer, flush, and a saturating back-pressure cycle counter.
// Optional feature macro: ILLEGAL_TRAP_EN (drives out_illegal).
module decode_stage_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    decode_stage_pipe_if.slave   bus,
    output logic [CNT_W-1:0]     stall_cnt
);

    buf_state_e       state_q, state_d;
    dec_entry_t       head_q, head_d;
    dec_entry_t       tail_q, tail_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    dec_entry_t       in_entry;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    decode_comb u_decode (
        .instr (bus.in_instr),
        .entry (in_entry)
    );

    // Acceptance depends only on occupancy, never on out_ready
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_EMPTY: in_ready = 1'b1;
            ST_ONE:   in_ready = (DEPTH == 2);
            ST_FULL:  in_ready = 1'b0;
            default:  in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign push      = bus.in_valid && in_ready && !flush;
    assign pop       = out_valid && bus.out_ready && !flush;

    // Buffer occupancy FSM and entry movement; flush overrides push and pop
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        head_d  = in_entry;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end else if (push) begin
                        state_d = ST_FULL;
                        tail_d  = in_entry;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        head_d  = tail_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Saturating count of cycles where the head is offered but not taken
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State, buffer and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_signals = head_q.signals;
    assign bus.out_aluctrl = head_q.aluctrl;
    assign bus.out_rs      = head_q.rs;
    assign bus.out_rt      = head_q.rt;
    assign bus.out_dest    = head_q.dest;
    assign bus.out_target  = head_q.target;
    assign bus.out_imm     = head_q.imm_sext ? XLEN'($signed(head_q.imm)) : XLEN'(head_q.imm);
    assign stall_cnt       = stall_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.out_illegal = head_q.illegal;
`else
    logic illegal_unused;
    assign illegal_unused = head_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_decode_stage_pipe;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    decode_stage_pipe_if #(.XLEN(XLEN)) bus ();

    decode_stage_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sig;
        logic [5:0]  alu;
        logic [4:0]  rs, rt, dest;
        logic [31:0] imm;
        logic [25:0] target;
        logic        illegal;
        logic        rtype;
    } exp_t;

    exp_t        q[$];
    int unsigned m_stall;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference decode straight from the opcode table
    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        logic [31:0] sx, zx;
        sx = {{16{i[15]}}, i[15:0]};
        zx = {16'h0000, i[15:0]};
        e.rs = i[25:21]; e.rt = i[20:16]; e.dest = i[20:16]; e.target = i[25:0];
        e.imm = zx; e.illegal = 1'b0; e.rtype = 1'b0; e.sig = 8'h00; e.alu = 6'h00;
        case (i[31:26])
            6'h00: begin
                e.rtype = 1'b1; e.dest = i[15:11]; e.alu = i[5:0];
                e.sig = i[5] ? 8'h20 : 8'h00;
`ifdef ILLEGAL_TRAP_EN
                if (!(i[5:0] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B})) begin
                    e.illegal = 1'b1; e.sig = 8'h00;
                end
`endif
            end
            6'h23: begin e.sig = 8'hF0; e.alu = 6'h20; e.imm = sx; end
            6'h2B: begin e.sig = 8'h88; e.alu = 6'h20; e.imm = sx; end
            6'h04: begin e.sig = 8'h06; e.alu = 6'h22; e.imm = sx; end
            6'h05: begin e.sig = 8'h04; e.alu = 6'h22; e.imm = sx; end
            6'h08: begin e.sig = 8'hA0; e.alu = 6'h20; e.imm = sx; end
            6'h09: begin e.sig = 8'hA0; e.alu = 6'h21; e.imm = sx; end
            6'h0C: begin e.sig = 8'hA0; e.alu = 6'h24; end
            6'h0D: begin e.sig = 8'hA0; e.alu = 6'h25; end
            6'h0A: begin e.sig = 8'hA0; e.alu = 6'h2A; e.imm = sx; end
            6'h0B: begin e.sig = 8'hA0; e.alu = 6'h2B; e.imm = sx; end
            6'h02: begin e.sig = 8'h01; e.alu = 6'h00; end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                e.illegal = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs, advance the clock and the reference model
    task automatic tick(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        bit   do_push, do_pop, do_stall;
        exp_t dropped;
        bus.in_valid = v; bus.in_instr = ins; bus.out_ready = rdy; flush = fl;
        do_push  = v && (q.size() < DEPTH) && !fl;
        do_pop   = (q.size() > 0) && rdy && !fl;
        do_stall = (q.size() > 0) && !rdy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) dropped = q.pop_front();
            if (do_push) q.push_back(ref_decode(ins));
        end
        if (do_stall && m_stall != (2**CNT_W - 1)) m_stall++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.out_ready = 1'b0;
        q.delete(); m_stall = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        n_tests++; if ({bus.out_signals, bus.out_aluctrl, bus.out_dest, bus.out_imm} !== 51'd0) begin n_fail++;
            $display("FAIL reset_data got sig=%h alu=%h dest=%h imm=%h want 0", bus.out_signals, bus.out_aluctrl, bus.out_dest, bus.out_imm); end
    endtask

    task automatic test_lw();
        tick(1'b1, 32'h8C220004, 1'b1, 1'b0);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid got %b want 1", bus.out_valid); end
        n_tests++; if (bus.out_signals !== 8'hF0) begin n_fail++; $display("FAIL lw_sig got %h want f0", bus.out_signals); end
        n_tests++; if (bus.out_aluctrl !== 6'h20) begin n_fail++; $display("FAIL lw_alu got %h want 20", bus.out_aluctrl); end
        n_tests++; if ({bus.out_rs, bus.out_rt, bus.out_dest} !== {5'd1, 5'd2, 5'd2}) begin n_fail++;
            $display("FAIL lw_regs got rs=%0d rt=%0d dest=%0d want 1 2 2", bus.out_rs, bus.out_rt, bus.out_dest); end
        n_tests++; if (bus.out_imm !== 32'h00000004) begin n_fail++; $display("FAIL lw_imm got %h want 00000004", bus.out_imm); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 32'h00221820, 1'b1, 1'b0);
        n_tests++; if ({bus.out_signals, bus.out_dest, bus.out_aluctrl} !== {8'h20, 5'd3, 6'h20}) begin n_fail++;
            $display("FAIL add_head got sig=%h dest=%0d alu=%h want 20 3 20", bus.out_signals, bus.out_dest, bus.out_aluctrl); end
        tick(1'b1, 32'h1022FFFF, 1'b1, 1'b0);
        n_tests++; if ({bus.out_valid, bus.out_signals, bus.out_aluctrl} !== {1'b1, 8'h06, 6'h22}) begin n_fail++;
            $display("FAIL beq_head got v=%b sig=%h alu=%h want 1 06 22", bus.out_valid, bus.out_signals, bus.out_aluctrl); end
        n_tests++; if (bus.out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL beq_imm got %h want ffffffff", bus.out_imm); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_andi();
        tick(1'b1, 32'h3022FFFF, 1'b1, 1'b0);
        n_tests++; if ({bus.out_imm, bus.out_signals, bus.out_aluctrl} !== {32'h0000FFFF, 8'hA0, 6'h24}) begin n_fail++;
            $display("FAIL andi got imm=%h sig=%h alu=%h want 0000ffff a0 24", bus.out_imm, bus.out_signals, bus.out_aluctrl); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int unsigned s0;
        s0 = m_stall;
        tick(1'b1, 32'h8C220004, 1'b0, 1'b0);   // lw, dest 2
        n_tests++; if ({bus.out_valid, bus.in_ready} !== 2'b11) begin n_fail++; $display("FAIL bp_first got v=%b rdy=%b want 1 1", bus.out_valid, bus.in_ready); end
        tick(1'b1, 32'h20050007, 1'b0, 1'b0);   // addi, dest 5
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", bus.in_ready); end
        n_tests++; if (stall_cnt !== 16'(s0 + 1)) begin n_fail++; $display("FAIL bp_stall1 got %0d want %0d", stall_cnt, s0 + 1); end
        tick(1'b1, 32'hAC090000, 1'b0, 1'b0);   // sw, must be held off
        n_tests++; if (stall_cnt !== 16'(s0 + 2)) begin n_fail++; $display("FAIL bp_stall2 got %0d want %0d", stall_cnt, s0 + 2); end
        n_tests++; if ({bus.out_signals, bus.out_dest} !== {8'hF0, 5'd2}) begin n_fail++;
            $display("FAIL bp_head0 got sig=%h dest=%0d want f0 2", bus.out_signals, bus.out_dest); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++; if ({bus.out_valid, bus.out_signals, bus.out_dest} !== {1'b1, 8'hA0, 5'd5}) begin n_fail++;
            $display("FAIL bp_head1 got v=%b sig=%h dest=%0d want 1 a0 5", bus.out_valid, bus.out_signals, bus.out_dest); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_drain got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
        n_tests++; if (stall_cnt !== 16'(s0 + 2)) begin n_fail++; $display("FAIL bp_stall_hold got %0d want %0d", stall_cnt, s0 + 2); end
    endtask

    task automatic test_flush();
        tick(1'b1, 32'h8C220004, 1'b0, 1'b0);
        tick(1'b1, 32'h8C230008, 1'b0, 1'b0);
        tick(1'b1, 32'h08000123, 1'b0, 1'b1);
        n_tests++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_state got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
        n_tests++; if (stall_cnt !== 16'(m_stall) || m_stall == 0) begin n_fail++; $display("FAIL flush_stall_kept got %0d want %0d", stall_cnt, m_stall); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost got %b want 0", bus.out_valid); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        w = $urandom;
        case ($urandom_range(0, 13))
            0: op = 6'h00;  1: op = 6'h02;  2: op = 6'h04;  3: op = 6'h05;
            4: op = 6'h08;  5: op = 6'h09;  6: op = 6'h0A;  7: op = 6'h0B;
            8: op = 6'h0C;  9: op = 6'h0D; 10: op = 6'h23; 11: op = 6'h2B;
            12: op = 6'h3F; default: op = 6'($urandom);
        endcase
        w[31:26] = op;
        if (op == 6'h00 && $urandom_range(0, 3) != 0) w[5:0] = 6'h20 + 6'($urandom_range(0, 5));
        return w;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            tick($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            n_tests++; if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < DEPTH)) begin n_fail++;
                $display("FAIL rnd_flow cyc %0d got v=%b rdy=%b want v=%b rdy=%b", n, bus.out_valid, bus.in_ready, q.size() > 0, q.size() < DEPTH); end
            n_tests++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", n, stall_cnt, m_stall); end
            if (q.size() > 0) begin
                n_tests++;
                if ({bus.out_signals, bus.out_aluctrl, bus.out_rs, bus.out_rt, bus.out_dest, bus.out_target} !==
                    {q[0].sig, q[0].alu, q[0].rs, q[0].rt, q[0].dest, q[0].target}) begin n_fail++;
                    $display("FAIL rnd_head cyc %0d got sig=%h alu=%h rs=%0d rt=%0d d=%0d t=%h want sig=%h alu=%h rs=%0d rt=%0d d=%0d t=%h",
                        n, bus.out_signals, bus.out_aluctrl, bus.out_rs, bus.out_rt, bus.out_dest, bus.out_target,
                        q[0].sig, q[0].alu, q[0].rs, q[0].rt, q[0].dest, q[0].target); end
                if (!q[0].rtype) begin
                    n_tests++; if (bus.out_imm !== q[0].imm) begin n_fail++; $display("FAIL rnd_imm cyc %0d got %h want %h", n, bus.out_imm, q[0].imm); end
                end
`ifdef ILLEGAL_TRAP_EN
                n_tests++; if (bus.out_illegal !== q[0].illegal) begin n_fail++; $display("FAIL rnd_illegal cyc %0d got %b want %b", n, bus.out_illegal, q[0].illegal); end
`endif
            end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset_illegal();
        tick(1'b1, 32'h8C220004, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({bus.out_valid, bus.in_ready, bus.out_signals, bus.out_imm} !== {1'b0, 1'b1, 8'h00, 32'h0}) begin n_fail++;
            $display("FAIL async_rst got v=%b rdy=%b sig=%h imm=%h want 0 1 00 0", bus.out_valid, bus.in_ready, bus.out_signals, bus.out_imm); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_stall got %0d want 0", stall_cnt); end
        q.delete(); m_stall = 0;
        @(posedge clk); #1 rst = 1'b0;
        tick(1'b1, 32'hFC228001, 1'b1, 1'b0);
        n_tests++; if ({bus.out_valid, bus.out_signals, bus.out_aluctrl, bus.out_imm} !== {1'b1, 8'h00, 6'h00, 32'h00008001}) begin n_fail++;
            $display("FAIL op3f got v=%b sig=%h alu=%h imm=%h want 1 00 00 00008001", bus.out_valid, bus.out_signals, bus.out_aluctrl, bus.out_imm); end
`ifdef ILLEGAL_TRAP_EN
        n_tests++; if (bus.out_illegal !== 1'b1) begin n_fail++; $display("FAIL op3f_illegal got %b want 1", bus.out_illegal); end
`endif
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_back_to_back();
        test_andi();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
